// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
//   8N1-style UART receiver driven by a 16x (OVERSAMPLE) baud tick.
//   rx is brought in through a two-flop synchroniser. A start bit is detected
//   and then confirmed at its mid-point. Each data bit is sampled at its
//   mid-point, LSB first. The stop bit is checked at its mid-point, so the
//   receiver is idle again half a bit early and back-to-back frames work.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   baud_tick  in   one-cycle oversample strobe, OVERSAMPLE pulses per bit
//   rx         in   asynchronous serial input, idle high
//   data       out  last correctly received word, held until the next good frame
//   data_valid out  one-cycle pulse, data updated this cycle
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   busy       out  high whenever the receiver is not idle
module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_m, rx_s;
  logic [TW-1:0]        tick_cnt, tick_cnt_nxt;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 load_data, flag_err;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
    end
  end

  // Next-state logic; everything advances only on baud_tick.
  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    if (baud_tick) begin
      unique case (state)
        S_IDLE: begin
          if (!rx_s) begin
            tick_cnt_nxt = '0;
            state_nxt    = S_START;
          end
        end
        S_START: begin
          if (tick_cnt == T_MID) begin
            if (rx_s) begin
              state_nxt = S_IDLE;  // glitch, not a real start bit
            end else begin
              tick_cnt_nxt = '0;
              bit_cnt_nxt  = '0;
              state_nxt    = S_DATA;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_cnt == T_LAST) begin
            shreg_nxt    = {rx_s, shreg[DATA_BITS-1:1]};
            tick_cnt_nxt = '0;
            bit_cnt_nxt  = bit_cnt + 1'b1;
            if (bit_cnt == B_LAST) begin
              state_nxt = S_STOP;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_cnt == T_LAST) begin
            state_nxt = rx_s ? S_IDLE : S_BREAK;
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          // Held-low line must return high before a new start is accepted.
          if (rx_s) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode: stop-bit verdict and busy flag.
  always_comb begin
    load_data = 1'b0;
    flag_err  = 1'b0;
    if (baud_tick && (state == S_STOP) && (tick_cnt == T_LAST)) begin
      load_data = rx_s;
      flag_err  = !rx_s;
    end
    busy = (state != S_IDLE);
  end

  // Registered strobes and the held output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= load_data;
      frame_err  <= flag_err;
      if (load_data) begin
        data <= shreg;
      end
    end
  end

endmodule
